// File: rtl/snake_game_pkg.sv
// Shared snake game types and default constants.
// Holds the hazard FSM state enum, lives width and parameter defaults.
package snake_game_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        HIT    = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } hazard_state_t;

    localparam int unsigned LIVES_W           = 3;
    localparam int unsigned LIVES_DEF         = 3;
    localparam int unsigned INVULN_FRAMES_DEF = 60;
    localparam int unsigned BLINK_FRAMES_DEF  = 8;

endpackage

// File: rtl/hazard_frame_timer.sv
// Loadable down-counter advanced by frame ticks.
// Ports: clk, reset (sync, active-low), load_i/load_val_i reload the count,
// tick_i decrements, expire_o flags the tick that takes the count 1 -> 0.
module hazard_frame_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = tick_i && (cnt_q == W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_hazard_ctrl.sv
// Turns the spider collision level into lives, respawn, invulnerability and
// game over. Ports: clk, reset (sync, active-low), frame_tick, hazard_hit,
// start in; lives, hit_pulse, respawn, invuln, snake_visible, game_over out.
// Macro SNAKE_HAZARD_BLINK_EN adds a blinking snake_visible during INVULN.
module snake_hazard_ctrl
    import snake_game_pkg::*;
#(
    parameter int unsigned LIVES         = LIVES_DEF,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int unsigned BLINK_FRAMES  = BLINK_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               hazard_hit,
    input  logic               start,
    output logic [LIVES_W-1:0] lives,
    output logic               hit_pulse,
    output logic               respawn,
    output logic               invuln,
    output logic               snake_visible,
    output logic               game_over
);

    localparam int unsigned IW = $clog2(INVULN_FRAMES + 1);

    if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
        $error("LIVES must be 1..7");
    end
    if (INVULN_FRAMES < 1) begin : g_bad_invuln
        $error("INVULN_FRAMES must be >= 1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be >= 1");
    end

    hazard_state_t      state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               inv_load;
    logic               inv_tick;
    logic               inv_expire;

    // Ticks only count inside INVULN, so a tick during HIT is dropped.
    assign inv_tick = frame_tick && (state_q == INVULN);

    hazard_frame_timer #(
        .W (IW)
    ) u_inv_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (inv_load),
        .load_val_i (IW'(INVULN_FRAMES)),
        .tick_i     (inv_tick),
        .expire_o   (inv_expire)
    );

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        inv_load = 1'b0;
        unique case (state_q)
            PLAY: begin
                if (hazard_hit) begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = HIT;
                end
            end
            HIT: begin
                if (lives_q != '0) begin
                    inv_load = 1'b1;
                    state_d  = INVULN;
                end else begin
                    state_d = OVER;
                end
            end
            INVULN: begin
                if (inv_expire) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (start) begin
                    lives_d = LIVES_W'(LIVES);
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PLAY;
            lives_q <= LIVES_W'(LIVES);
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
        end
    end

    assign lives     = lives_q;
    assign hit_pulse = (state_q == HIT);
    assign respawn   = (state_q == HIT) && (lives_q != '0);
    assign invuln    = (state_q == INVULN);
    assign game_over = (state_q == OVER);

`ifdef SNAKE_HAZARD_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    logic blink_expire;
    logic vis_q, vis_d;

    // Reloaded on INVULN entry and after every half-period.
    hazard_frame_timer #(
        .W (BW)
    ) u_blink_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (inv_load || blink_expire),
        .load_val_i (BW'(BLINK_FRAMES)),
        .tick_i     (inv_tick),
        .expire_o   (blink_expire)
    );

    // Leaving INVULN forces visible even if a blink edge lands on that tick.
    always_comb begin
        vis_d = vis_q;
        unique case (state_q)
            HIT:    vis_d = 1'b0;
            INVULN: begin
                if (inv_expire) begin
                    vis_d = 1'b1;
                end else if (blink_expire) begin
                    vis_d = ~vis_q;
                end
            end
            OVER:   vis_d = start;
            default: vis_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vis_q <= 1'b1;
        end else begin
            vis_q <= vis_d;
        end
    end

    assign snake_visible = vis_q;
`else
    assign snake_visible = 1'b1;
`endif

endmodule

// File: tb/tb_snake_hazard_ctrl.sv
// Self-checking bench for snake_hazard_ctrl: directed vector table plus
// randomized traffic against a frame-counting reference model.
module tb_snake_hazard_ctrl;

    localparam int LIVES_P  = 3;
    localparam int INVF_P   = 4;
    localparam int BLINKF_P = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hazard_hit = 1'b0;
    logic       start = 1'b0;
    logic [2:0] lives;
    logic       hit_pulse;
    logic       respawn;
    logic       invuln;
    logic       snake_visible;
    logic       game_over;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    snake_hazard_ctrl #(
        .LIVES         (LIVES_P),
        .INVULN_FRAMES (INVF_P),
        .BLINK_FRAMES  (BLINKF_P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .hazard_hit    (hazard_hit),
        .start         (start),
        .lives         (lives),
        .hit_pulse     (hit_pulse),
        .respawn       (respawn),
        .invuln        (invuln),
        .snake_visible (snake_visible),
        .game_over     (game_over)
    );

    typedef struct {
        logic       rst_n;
        logic       hz;
        logic       ft;
        logic       st;
        logic [2:0] lv;
        logic       hp;
        logic       rs;
        logic       iv;
        logic       go;
        logic       vs;
    } vec_t;

    localparam int NV = 26;
    vec_t tab [NV];

    // Reference model: phase plus count of frame ticks seen in INVULN.
    localparam int M_PLAY = 0;
    localparam int M_HIT  = 1;
    localparam int M_INV  = 2;
    localparam int M_OVER = 3;
    int m_ph;
    int m_lv;
    int m_tk;

    function automatic logic blink_vis(input logic v);
`ifdef SNAKE_HAZARD_BLINK_EN
        return v;
`else
        return 1'b1 | v;
`endif
    endfunction

    task automatic compare(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {lives, hit_pulse, respawn, invuln, game_over, snake_visible};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got lives/hp/rs/inv/go/vis=%b expected %b",
                     name, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic h, input logic f,
                         input logic s);
        reset      = r;
        hazard_hit = h;
        frame_tick = f;
        start      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic h, input logic f,
                              input logic s);
        if (!r) begin
            m_ph = M_PLAY;
            m_lv = LIVES_P;
            m_tk = 0;
        end else begin
            case (m_ph)
                M_PLAY: if (h) begin
                    m_lv = m_lv - 1;
                    m_ph = M_HIT;
                end
                M_HIT: begin
                    m_tk = 0;
                    m_ph = (m_lv > 0) ? M_INV : M_OVER;
                end
                M_INV: if (f) begin
                    m_tk = m_tk + 1;
                    if (m_tk == INVF_P) m_ph = M_PLAY;
                end
                default: if (s) begin
                    m_lv = LIVES_P;
                    m_ph = M_PLAY;
                end
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic v;
        if (m_ph == M_INV)       v = ((m_tk / BLINKF_P) % 2) == 1;
        else if (m_ph == M_OVER) v = 1'b0;
        else                     v = 1'b1;
        return {3'(m_lv), m_ph == M_HIT, (m_ph == M_HIT) && (m_lv > 0),
                m_ph == M_INV, m_ph == M_OVER, blink_vis(v)};
    endfunction

    initial begin
        //          rst hz ft st  lv  hp rs iv go vs
        tab[0]  = '{0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 1};
        tab[1]  = '{0, 1, 1, 1, 3'd3, 0, 0, 0, 0, 1};
        tab[2]  = '{1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 1};
        tab[3]  = '{1, 1, 0, 0, 3'd2, 1, 1, 0, 0, 1};
        tab[4]  = '{1, 1, 0, 0, 3'd2, 0, 0, 1, 0, 0};
        tab[5]  = '{1, 1, 1, 0, 3'd2, 0, 0, 1, 0, 0};
        tab[6]  = '{1, 1, 0, 0, 3'd2, 0, 0, 1, 0, 0};
        tab[7]  = '{1, 1, 1, 0, 3'd2, 0, 0, 1, 0, 1};
        tab[8]  = '{1, 1, 1, 0, 3'd2, 0, 0, 1, 0, 1};
        tab[9]  = '{1, 1, 1, 0, 3'd2, 0, 0, 0, 0, 1};
        tab[10] = '{1, 1, 0, 0, 3'd1, 1, 1, 0, 0, 1};
        tab[11] = '{1, 0, 1, 0, 3'd1, 0, 0, 1, 0, 0};
        tab[12] = '{1, 0, 1, 0, 3'd1, 0, 0, 1, 0, 0};
        tab[13] = '{1, 0, 1, 0, 3'd1, 0, 0, 1, 0, 1};
        tab[14] = '{1, 0, 1, 0, 3'd1, 0, 0, 1, 0, 1};
        tab[15] = '{1, 0, 1, 0, 3'd1, 0, 0, 0, 0, 1};
        tab[16] = '{1, 1, 1, 0, 3'd0, 1, 0, 0, 0, 1};
        tab[17] = '{1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0};
        tab[18] = '{1, 1, 1, 0, 3'd0, 0, 0, 0, 1, 0};
        tab[19] = '{1, 1, 0, 1, 3'd3, 0, 0, 0, 0, 1};
        tab[20] = '{1, 1, 0, 0, 3'd2, 1, 1, 0, 0, 1};
        tab[21] = '{1, 0, 0, 0, 3'd2, 0, 0, 1, 0, 0};
        tab[22] = '{1, 0, 1, 0, 3'd2, 0, 0, 1, 0, 0};
        tab[23] = '{0, 1, 1, 1, 3'd3, 0, 0, 0, 0, 1};
        tab[24] = '{1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 1};
        tab[25] = '{1, 0, 0, 1, 3'd3, 0, 0, 0, 0, 1};

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            apply(tab[i].rst_n, tab[i].hz, tab[i].ft, tab[i].st);
            compare($sformatf("vec%0d", i),
                    {tab[i].lv, tab[i].hp, tab[i].rs, tab[i].iv, tab[i].go,
                     blink_vis(tab[i].vs)});
        end

        // Hand sequence: hit level held across the whole window re-hits
        // on the first PLAY cycle after INVULN ends.
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 + INVF_P + 2; i++) begin
            logic f;
            f = (i >= 2);
            apply(1'b1, 1'b1, f, 1'b0);
            model_step(1'b1, 1'b1, f, 1'b0);
            compare($sformatf("held_hit%0d", i), model_out());
        end

        // Randomized traffic against the reference model.
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        compare("rand_reset", model_out());
        for (int i = 0; i < 3000; i++) begin
            logic r, h, f, s;
            r = ($urandom_range(0, 199) != 0);
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 3) == 0);
            apply(r, h, f, s);
            model_step(r, h, f, s);
            compare($sformatf("rand%0d", i), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snake_hazard_ctrl.md
# snake_hazard_ctrl

Downstream consumer of the spider collision flag (`spider_en`). It turns the raw, level-held hazard hit into game consequences: life loss, a respawn request to the snake datapath, a frame-counted invulnerability window and game over. It sits between the spider collision logic and the snake movement and render logic.

## Interface

**Parameters**
- `LIVES`, 3, lives loaded at reset and at restart; legal range 1..7.
- `INVULN_FRAMES`, 60, length of the post-hit invulnerability window in frames; minimum 1.
- `BLINK_FRAMES`, 8, frames per half-period of the invulnerability blink; minimum 1.

**Ports**
- `clk`, in, 1, system clock.
- `reset`, in, 1, synchronous, active-low reset.
- `frame_tick`, in, 1, one-cycle pulse per video frame.
- `hazard_hit`, in, 1, collision level from the spider datapath; may stay high for many cycles.
- `start`, in, 1, restart pulse; honoured only in OVER.
- `lives`, out, 3, remaining lives.
- `hit_pulse`, out, 1, one-cycle pulse per accepted hit.
- `respawn`, out, 1, one-cycle pulse that tells the snake datapath to reload its start position.
- `invuln`, out, 1, high while hazards are ignored.
- `snake_visible`, out, 1, render enable for the snake sprite.
- `game_over`, out, 1, high in OVER.

## Operation

**States:** PLAY, HIT, INVULN, OVER. Every output is decoded from registered state, counters or `lives`.

- **PLAY**
  - If `hazard_hit`=1: decrement `lives`, go to HIT.
  - Otherwise stay.
- **HIT** (exactly 1 cycle)
  - `hit_pulse`=1.
  - If `lives`≠0: `respawn`=1, load the invulnerability counter with `INVULN_FRAMES`, go to INVULN.
  - If `lives`=0: go to OVER, no `respawn`.
- **INVULN**
  - `invuln`=1; `hazard_hit` is ignored.
  - Each `frame_tick` decrements the counter.
  - When a `frame_tick` arrives with counter=1: go to PLAY.
- **OVER**
  - `game_over`=1; `lives`=0; `hazard_hit` is ignored.
  - `start`=1: reload `lives`=`LIVES`, go to PLAY.
- `start` is ignored outside OVER.

**Widths and arithmetic**
- Counter width is `$clog2(INVULN_FRAMES+1)`.
- `lives` never underflows: it is only decremented from PLAY, and PLAY is unreachable with `lives`=0.

**Reset** (any state, including mid-INVULN):
- State PLAY, `lives`=`LIVES`, counters 0.
- `hit_pulse`, `respawn`, `invuln`, `game_over` all 0.
- `snake_visible`=1.

## Timing

- `hazard_hit` sampled high in PLAY at cycle N: HIT at N+1 (`hit_pulse`/`respawn` high, `lives` already decremented), INVULN or OVER at N+2.
- A `hazard_hit` level still present on return to PLAY causes a new hit. This is intended; the respawn must have moved the snake away.
- Simultaneous `hazard_hit` and `frame_tick` in PLAY: the hit wins and the tick is dropped.
- `frame_tick` during HIT is dropped. Invulnerability therefore spans exactly `INVULN_FRAMES` ticks counted from the INVULN entry cycle.
- `start` and `hazard_hit` both high in OVER: go to PLAY. `hazard_hit` is evaluated from the next cycle.
- Holding `reset` low overrides all inputs.

## Configuration

**Macro `SNAKE_HAZARD_BLINK_EN`**

- **Defined:**
  - In INVULN, `snake_visible` toggles every `BLINK_FRAMES` frame ticks, starting at 0 on INVULN entry.
  - It is forced to 1 on leaving INVULN.
  - In OVER it is 0.
- **Undefined:**
  - `snake_visible` is constant 1.
  - No blink counter is built.

## Structure

**Shared package `snake_game_pkg`:**
- `hazard_state_t` enum (PLAY, HIT, INVULN, OVER).
- Default constants for `LIVES`, `INVULN_FRAMES` and `BLINK_FRAMES`.
- Lives width constant `LIVES_W`=3.

**Sub-module `hazard_frame_timer`:**
- Loadable down-counter advanced by `frame_tick`.
- Raises `expire` on the tick that takes the count from 1 to 0.
- Instantiated once for invulnerability, and once more for blink when `SNAKE_HAZARD_BLINK_EN` is defined.

## Test plan

Bench parameters: `LIVES`=3, `INVULN_FRAMES`=4, `BLINK_FRAMES`=2.

- **Reset state:** hold `reset`=0 for 2 cycles -> `lives`=3, all pulse and flag outputs 0, `snake_visible`=1.
- **First hit:** one-cycle `hazard_hit` in PLAY -> next cycle `hit_pulse`=1, `respawn`=1, `lives`=2; following cycle `invuln`=1.
- **Hits ignored while invulnerable:** hold `hazard_hit`=1 through INVULN, then issue 4 `frame_tick`s -> `lives` stays 2 until `invuln` drops; then a second hit gives `lives`=1.
- **Game over:** third hit -> `lives`=0, `respawn` stays 0, `game_over`=1 two cycles after the hit. Then `start`=1 -> PLAY, `lives`=3, `game_over`=0.
- **Simultaneous events:** `hazard_hit` and `frame_tick` together in PLAY -> exactly one `hit_pulse`. Reset asserted mid-INVULN -> `invuln`=0, `lives`=3 next cycle.
- **Blink (`SNAKE_HAZARD_BLINK_EN` defined):** during INVULN, `snake_visible` reads 0,0,1,1 over 4 frame ticks, then 1 after exit.
